// File: rtl/counter_mmio_arbiter.sv
// Round-robin arbiter sharing the timer/counter MMIO port between the core (r0) and debug (r1).
// Define COUNTER_MMIO_ARB_LOCK_EN to let a requester hold the port across read-modify-write.
module counter_mmio_arbiter #(
  parameter int MEM_ADDR_R = 63,
  parameter int MEM_DATA_R = 63
) (
  input  logic                g_clk,
  input  logic                g_resetn,
  input  logic                r0_req_i,
  input  logic                r0_wen_i,
  input  logic [MEM_ADDR_R:0] r0_addr_i,
  input  logic [MEM_DATA_R:0] r0_wdata_i,
  input  logic                r0_lock_i,
  output logic                r0_gnt_o,
  output logic                r0_rsp_o,
  output logic [MEM_DATA_R:0] r0_rdata_o,
  output logic                r0_error_o,
  input  logic                r1_req_i,
  input  logic                r1_wen_i,
  input  logic [MEM_ADDR_R:0] r1_addr_i,
  input  logic [MEM_DATA_R:0] r1_wdata_i,
  input  logic                r1_lock_i,
  output logic                r1_gnt_o,
  output logic                r1_rsp_o,
  output logic [MEM_DATA_R:0] r1_rdata_o,
  output logic                r1_error_o,
  output logic                mmio_req_o,
  output logic                mmio_wen_o,
  output logic [MEM_ADDR_R:0] mmio_addr_o,
  output logic [MEM_DATA_R:0] mmio_wdata_o,
  input  logic                mmio_gnt_i,
  input  logic [MEM_DATA_R:0] mmio_rdata_i,
  input  logic                mmio_error_i
);

  logic sel;
  logic req_any;
  logic accept;
  logic last_grant_q;
  logic rsp_owner_q;
  logic rsp_pend_q;
  logic lock0_hold;
  logic lock1_hold;

`ifdef COUNTER_MMIO_ARB_LOCK_EN
  typedef enum logic [1:0] {StArb, StLocked0, StLocked1} state_e;
  state_e state_q;

  // A lock lapses in the same cycle its owner drops rK_lock, so that cycle arbitrates normally.
  assign lock0_hold = (state_q == StLocked0) && r0_lock_i;
  assign lock1_hold = (state_q == StLocked1) && r1_lock_i;
`else
  logic unused_lock;
  assign unused_lock = r0_lock_i | r1_lock_i;
  assign lock0_hold  = 1'b0;
  assign lock1_hold  = 1'b0;
`endif

  always_comb begin
    sel     = 1'b0;
    req_any = 1'b0;
    if (lock0_hold) begin
      sel     = 1'b0;
      req_any = r0_req_i;
    end else if (lock1_hold) begin
      sel     = 1'b1;
      req_any = r1_req_i;
    end else begin
      req_any = r0_req_i | r1_req_i;
      if (r0_req_i && r1_req_i) begin
        sel = ~last_grant_q;
      end else begin
        sel = r1_req_i;
      end
    end
  end

  assign accept       = req_any & mmio_gnt_i;
  assign mmio_req_o   = req_any;
  assign mmio_wen_o   = req_any & (sel ? r1_wen_i : r0_wen_i);
  assign mmio_addr_o  = req_any ? (sel ? r1_addr_i : r0_addr_i) : '0;
  assign mmio_wdata_o = req_any ? (sel ? r1_wdata_i : r0_wdata_i) : '0;

  assign r0_gnt_o = accept & ~sel;
  assign r1_gnt_o = accept & sel;

  assign r0_rsp_o   = rsp_pend_q & ~rsp_owner_q;
  assign r1_rsp_o   = rsp_pend_q & rsp_owner_q;
  assign r0_rdata_o = {(MEM_DATA_R + 1){r0_rsp_o}} & mmio_rdata_i;
  assign r1_rdata_o = {(MEM_DATA_R + 1){r1_rsp_o}} & mmio_rdata_i;
  assign r0_error_o = r0_rsp_o & mmio_error_i;
  assign r1_error_o = r1_rsp_o & mmio_error_i;

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      last_grant_q <= 1'b1;
      rsp_owner_q  <= 1'b0;
      rsp_pend_q   <= 1'b0;
`ifdef COUNTER_MMIO_ARB_LOCK_EN
      state_q      <= StArb;
`endif
    end else begin
      rsp_pend_q <= accept;
      if (accept) begin
        last_grant_q <= sel;
        rsp_owner_q  <= sel;
      end
`ifdef COUNTER_MMIO_ARB_LOCK_EN
      if (lock0_hold || lock1_hold) begin
        state_q <= state_q;
      end else if (accept && (sel ? r1_lock_i : r0_lock_i)) begin
        state_q <= sel ? StLocked1 : StLocked0;
      end else begin
        state_q <= StArb;
      end
`endif
    end
  end

endmodule
